// File: rtl/event_enc_pkg.sv
// Shared constants, code type and decoder relation for the event encoder.
package event_enc_pkg;

  localparam int CODE_W = 3;
  localparam int N_IN   = 8;

  typedef logic [CODE_W-1:0] code_t;

  // The 3-to-8 decoder relation; also used to form the clear mask of a loaded code.
  function automatic logic [N_IN-1:0] onehot_of(input code_t c);
    logic [N_IN-1:0] m;
    m    = '0;
    m[c] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/priority_eight_to_three.sv
// Combinational 8-to-3 priority encoder from two 4-to-2 halves; bit 7 highest.
module priority_eight_to_three (
  input  logic [7:0] vec,
  output logic [2:0] code,
  output logic       any
);

  // Returns {any, code[1:0]} for one half, bit 3 highest.
  function automatic logic [2:0] four_to_two(input logic [3:0] v);
    if (v[3])      return 3'b111;
    else if (v[2]) return 3'b110;
    else if (v[1]) return 3'b101;
    else if (v[0]) return 3'b100;
    else           return 3'b000;
  endfunction

  logic [2:0] upper;
  logic [2:0] lower;

  assign upper = four_to_two(vec[7:4]);
  assign lower = four_to_two(vec[3:0]);
  assign any   = upper[2] | lower[2];
  assign code  = upper[2] ? {1'b1, upper[1:0]} : {1'b0, lower[1:0]};

endmodule

// File: rtl/eight_to_three_event_encoder.sv
// Collects event pulses as pending bits and emits one 3-bit code per event.
// Optional rotating priority: define EVENT_ENC_ROUND_ROBIN_EN.
module eight_to_three_event_encoder
  import event_enc_pkg::*;
#(
  parameter int CODE_W_P = event_enc_pkg::CODE_W,
  parameter int N_IN_P   = event_enc_pkg::N_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enab,
  input  logic [N_IN_P-1:0] req,
  output logic [CODE_W_P-1:0] out,
  output logic              valid,
  input  logic              ready,
  output logic              collide,
  output logic [N_IN_P-1:0] pending
);

  if (N_IN_P != (1 << CODE_W_P) || N_IN_P != N_IN || CODE_W_P != CODE_W) begin : g_bad_param
    $error("eight_to_three_event_encoder: N_IN must equal 2**CODE_W (8 lines, 3-bit code)");
  end

  // Handshake: out/valid form a registered source; a code transfers at a rising
  // edge with valid & ready, and out/valid never change while valid & ~ready.
  logic [N_IN-1:0] pend_q;
  code_t           out_q;
  logic            valid_q;
  logic            collide_q;

  logic [N_IN-1:0] sel_vec;
  logic [2:0]      enc_code;
  logic            any;
  code_t           sel_code;
  logic            take;
  logic            load;
  logic [N_IN-1:0] clr;
  logic [N_IN-1:0] pend_next;
  logic            collide_next;

`ifdef EVENT_ENC_ROUND_ROBIN_EN
  code_t             ptr_q;
  logic [2*N_IN-1:0] dbl;

  // Rotate so the bit just below the last grant lands at position 7.
  assign dbl      = {pend_q, pend_q} >> ptr_q;
  assign sel_vec  = dbl[N_IN-1:0];
  assign sel_code = enc_code + ptr_q;
`else
  assign sel_vec  = pend_q;
  assign sel_code = enc_code;
`endif

  priority_eight_to_three u_prio (
    .vec  (sel_vec),
    .code (enc_code),
    .any  (any)
  );

  assign take         = ~valid_q | ready;
  assign load         = take & any;
  assign clr          = load ? onehot_of(sel_code) : '0;
  // A fresh request on the bit being cleared re-arms it rather than colliding.
  assign pend_next    = (pend_q & ~clr) | (enab ? req : '0);
  assign collide_next = enab & |(req & pend_q & ~clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      collide_q <= 1'b0;
    end else begin
      pend_q    <= pend_next;
      collide_q <= collide_next;
      if (take) begin
        valid_q <= any;
        if (any) out_q <= sel_code;
      end
    end
  end

`ifdef EVENT_ENC_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (rst)       ptr_q <= code_t'(N_IN - 1);
    else if (load) ptr_q <= sel_code;
  end
`endif

  assign out     = out_q;
  assign valid   = valid_q;
  assign collide = collide_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_eight_to_three_event_encoder.sv
// Bench for eight_to_three_event_encoder: directed plan plus random traffic
// against a cycle-level reference model and an accepted-code scoreboard.
module tb_eight_to_three_event_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       enab;
  logic [7:0] req;
  logic [2:0] out;
  logic       valid;
  logic       ready;
  logic       collide;
  logic [7:0] pending;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] m_pend;
  logic [2:0] m_out;
  logic       m_valid;
  logic       m_coll;
  logic [2:0] m_ptr;
  logic [2:0] exp_q[$];

  eight_to_three_event_encoder dut (
    .clk     (clk),
    .rst     (rst),
    .enab    (enab),
    .req     (req),
    .out     (out),
    .valid   (valid),
    .ready   (ready),
    .collide (collide),
    .pending (pending)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Highest pending index searching downward from 'start', wrapping; -1 if empty.
  function automatic int pick(input logic [7:0] p, input logic [2:0] ptr);
    int start;
`ifdef EVENT_ENC_ROUND_ROBIN_EN
    start = (int'(ptr) + 7) % 8;
`else
    start = 7;
`endif
    for (int k = 0; k < 8; k++) begin
      int idx;
      idx = (start - k + 8) % 8;
      if (p[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic r, input logic e, input logic rd, input logic [7:0] rq);
    logic [7:0] clr;
    int sel;
    rst = r; enab = e; ready = rd; req = rq;
    if (r) begin
      m_pend = 8'h00; m_out = 3'd0; m_valid = 1'b0; m_coll = 1'b0; m_ptr = 3'd7;
      exp_q.delete();
    end else begin
      if (m_valid && rd) begin
        if (exp_q.size() == 0) check("sb_underflow", 8'd1, 8'd0);
        else check("accept_code", {5'd0, out}, {5'd0, exp_q.pop_front()});
      end
      clr = 8'h00;
      if (!m_valid || rd) begin
        sel = pick(m_pend, m_ptr);
        if (sel >= 0) begin
          clr[sel] = 1'b1;
          m_out    = sel[2:0];
          m_ptr    = sel[2:0];
          m_valid  = 1'b1;
          exp_q.push_back(sel[2:0]);
        end else begin
          m_valid = 1'b0;
        end
      end
      m_coll = e && ((rq & m_pend & ~clr) != 8'h00);
      m_pend = (m_pend & ~clr) | (e ? rq : 8'h00);
    end
    @(posedge clk);
    #1;
    check("valid", {7'd0, valid}, {7'd0, m_valid});
    check("pending", pending, m_pend);
    check("collide", {7'd0, collide}, {7'd0, m_coll});
    check("out", {5'd0, out}, {5'd0, m_out});
  endtask

  task automatic idle(input int n, input logic rd);
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b1, rd, 8'h00);
  endtask

  task automatic do_reset();
    drive_cycle(1'b1, 1'b1, 1'b1, 8'hFF);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_pending", pending, 8'h00);
    check("rst_out", {5'd0, out}, 8'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0] seq[8];
    rst = 1'b1; enab = 1'b0; req = 8'h00; ready = 1'b0;
    m_pend = 8'h00; m_out = 3'd0; m_valid = 1'b0; m_coll = 1'b0; m_ptr = 3'd7;
    #1;

    // Two events, one pulse, drained in priority order
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b1, 8'b0010_0100);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
    check("t1_out5", {5'd0, out}, 8'd5);
    check("t1_valid5", {7'd0, valid}, 8'd1);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
    check("t1_out2", {5'd0, out}, 8'd2);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
    check("t1_empty_valid", {7'd0, valid}, 8'd0);
    check("t1_empty_pend", pending, 8'h00);

`ifdef EVENT_ENC_ROUND_ROBIN_EN
    // All pending from reset with rotating priority
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b1, 8'hFF);
    seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
      check("rr_seq", {5'd0, out}, {5'd0, seq[i]});
    end
    // Bit 7 stays pending while bit 0 is re-pulsed on every grant
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h81);
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, (out == 3'd0 || !valid) ? 8'h01 : 8'h80);
      check("rr_alternate", {5'd0, out}, (i % 2 == 0) ? 8'd0 : 8'd7);
    end
    idle(4, 1'b1);
`else
    // All pending, stalled, then back-to-back drain
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b0, 8'hFF);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
      check("t2_stall_out", {5'd0, out}, 8'd7);
    end
    seq = '{3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    for (int i = 0; i < 7; i++) begin
      drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
      check("t2_seq", {5'd0, out}, {5'd0, seq[i]});
    end
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
    check("t2_done", {7'd0, valid}, 8'd0);

    // Re-pulse on a bit that is already pending
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h88);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h08);
    check("t3_collide_hi", {7'd0, collide}, 8'd1);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("t3_collide_lo", {7'd0, collide}, 8'd0);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
    check("t3_out3", {5'd0, out}, 8'd3);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
    check("t3_single3", {7'd0, valid}, 8'd0);

    // Re-pulse on the bit cleared by this cycle's load
    do_reset();
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h10);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'h10);
    check("t4_rearm", pending, 8'h10);
    check("t4_no_collide", {7'd0, collide}, 8'd0);
    drive_cycle(1'b0, 1'b1, 1'b1, 8'h00);
    check("t4_second4", {5'd0, out}, 8'd4);
    idle(2, 1'b1);
`endif

    // Capture disabled
    do_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h81);
    drive_cycle(1'b0, 1'b0, 1'b1, 8'h00);
    check("t5_enab_pend", pending, 8'h00);
    check("t5_enab_valid", {7'd0, valid}, 8'd0);

    // Reset while draining
    drive_cycle(1'b0, 1'b1, 1'b0, 8'hF0);
    drive_cycle(1'b0, 1'b1, 1'b0, 8'hF0);
    check("t5_full_pend", pending, 8'hF0);
    check("t5_full_valid", {7'd0, valid}, 8'd1);
    do_reset();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic [7:0] rq;
      r  = ($urandom_range(0, 99) == 0);
      rq = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      drive_cycle(r, ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) != 0), rq);
    end
    idle(12, 1'b1);
    check("final_empty", pending, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eight_to_three_event_encoder.md
Name: eight_to_three_event_encoder

Overview:
- Sequential counterpart of the team's 3-to-8 decoder.
- Collects event pulses on 8 one-hot/multi-hot request lines and holds them as pending.
- Emits one 3-bit code per accepted event over a valid/ready handshake, so downstream logic can re-expand the code with the 3-to-8 decoder.
- Sits between interrupt/event sources and a single-code consumer.

Parameters:
- CODE_W, 3, width of the output code.
- N_IN, 8, number of request lines; must equal 2**CODE_W (elaboration error otherwise).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- enab  input  1  capture enable; when 0, new req pulses are ignored, but pending events still drain.
- req  input  N_IN  event pulses; bit i high for one or more cycles marks event i.
- out  output  CODE_W  encoded index of the presented event.
- valid  output  1  out holds an event.
- ready  input  1  consumer accepts when valid & ready at a rising edge.
- collide  output  1  one-cycle pulse: an event was merged because its bit was already pending.
- pending  output  N_IN  current pending vector (status/debug).

Behaviour:
- Reset (rst high at an edge): pending=0, out=0, valid=0, collide=0. Everything in flight is discarded and requests in that cycle are ignored. rst dominates all other inputs.
- Capture, every edge: pending_next = (pending & ~clr) | (enab ? req : 0).
  - clr is the one-hot bit of the event loaded into the output register in this cycle, else 0.
  - A new req on the same bit being cleared wins: the bit stays pending as a fresh event.
- collide_next = enab & |(req & pending & ~clr).
  - It is a registered pulse.
  - Level-held req lines collide every cycle after the first capture. This is required behaviour: sources must pulse.
- Output register load condition: load = (~valid | ready) & |pending.
  - On load: out = index of highest set bit of pending (fixed priority, bit 7 highest); valid=1; clr = that bit.
  - If (~valid | ready) & ~|pending: valid=0 and out holds its previous value.
  - If valid & ~ready: out and valid hold stable. out must not change while valid is high and unaccepted.
- Selection uses the registered pending only, never same-cycle req.
- Latency: req seen at edge N → pending at N → valid/out at edge N+1 (earliest).
- Throughput: one code per cycle while ready=1 and pending is nonzero. Back-to-back accept with reload in the same cycle is required.
- Empty: no pending and output accepted → valid drops on the next edge. No bubble is inserted when pending is nonzero.
- All pending set with ready=1: codes 7,6,5,4,3,2,1,0 on 8 consecutive cycles.
- Starvation is possible under fixed priority; this is accepted unless the optional feature is enabled.

Optional Feature:
- Macro: EVENT_ENC_ROUND_ROBIN_EN.
- Defined:
  - Rotating priority. A last-grant pointer (CODE_W bits, reset to N_IN-1) is updated to the loaded code on every load.
  - Search starts at pointer-1, descending with wrap from 0 to N_IN-1.
  - All pending set, ready=1, from reset: 6,5,4,3,2,1,0,7.
- Undefined: fixed priority exactly as above; no pointer register exists.

Decomposition:
- Shared package event_enc_pkg:
  - CODE_W and N_IN constants.
  - A code_t typedef (logic [CODE_W-1:0]).
  - A function onehot_of(code_t) giving the N_IN-bit one-hot mask (the decoder relation, reused for clr).
- One sub-module: priority_eight_to_three.
  - Combinational, built from two four_to_two priority halves; the upper half has precedence.
  - Inputs: vec[7:0]. Outputs: code[2:0], any.
  - The round-robin variant rotates vec by the pointer before this sub-module and rotates the code back after it.

Test Plan:
- Reset, then req=8'b0010_0100 for one cycle, enab=1, ready=1 → cycle+1 out=5 valid=1; cycle+2 out=2 valid=1; cycle+3 valid=0, pending=0.
- req=8'hFF one cycle, ready=0 for 3 cycles, then ready=1 → out stays 7 while stalled, then 7,6,5,4,3,2,1,0 back-to-back; collide never pulses.
- req[3] pulse while bit 3 already pending → collide=1 for exactly one cycle; only one code 3 is emitted.
- Bit 4 loaded (clr) in the same cycle req[4] pulses again → pending[4] remains 1; code 4 is emitted twice in total.
- enab=0 with req=8'h81 → pending unchanged, valid stays 0. Assert rst mid-drain with pending=8'hF0, valid=1 → next edge valid=0, pending=0, out=0.
- With EVENT_ENC_ROUND_ROBIN_EN: req=8'hFF, ready=1 → 6,5,4,3,2,1,0,7. Then req[7] held pending plus req[0] re-pulsed each grant → grants alternate 0/7, so no starvation.
